// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard-tracking pipeline.
package hazard_pkg;

  localparam int DEFAULT_REG_AW = 5;
  localparam int REG_X0 = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_pipe_stage.sv
// One pipeline stage holding {valid, rd, data}; stall holds the entry,
// flush clears its valid bit in place while stalled.
module hazard_pipe_stage
  import hazard_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = DEFAULT_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_valid,
  input  logic [REG_AW-1:0] load_rd,
  input  logic [WIDTH-1:0]  load_data,
  output logic              valid,
  output logic [REG_AW-1:0] rd,
  output logic [WIDTH-1:0]  data
);

  // When not stalled, any flush of this stage's old content is folded into
  // load_valid by the stage downstream of it, so flush only matters here
  // while the entry is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      rd    <= '0;
      data  <= '0;
    end else if (stall) begin
      valid <= valid & ~flush;
    end else begin
      valid <= load_valid;
      rd    <= load_rd;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/hazard_pipe.sv
// DEPTH-stage rd/payload pipe with stall, per-stage flush and an optional
// forwarding lookup built when HAZARD_PIPE_FWD_EN is defined.
module hazard_pipe
  import hazard_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 3,
  parameter int REG_AW = DEFAULT_REG_AW,
  localparam int SW    = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [DEPTH-1:0]  flush,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [WIDTH-1:0]  in_data,
  output logic [DEPTH-1:0]  stage_valid,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_rd,
  output logic [WIDTH-1:0]  out_data
`ifdef HAZARD_PIPE_FWD_EN
  ,
  input  logic [REG_AW-1:0] q_rs,
  output logic              fwd_hit,
  output logic [WIDTH-1:0]  fwd_data,
  output logic [SW-1:0]     fwd_stage
`endif
);

  logic [DEPTH-1:0]  v;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [WIDTH-1:0]  data_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              lv;
    logic [REG_AW-1:0] lrd;
    logic [WIDTH-1:0]  ld;

    if (i == 0) begin : g_head
      // x0 is never a hazard, so it enters the pipe already invalid
      assign lv  = in_valid & (in_rd != REG_AW'(REG_X0));
      assign lrd = in_rd;
      assign ld  = in_data;
    end else begin : g_body
      assign lv  = v[i-1] & ~flush[i-1];
      assign lrd = rd_q[i-1];
      assign ld  = data_q[i-1];
    end

    hazard_pipe_stage #(
      .WIDTH  (WIDTH),
      .REG_AW (REG_AW)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .flush      (flush[i]),
      .load_valid (lv),
      .load_rd    (lrd),
      .load_data  (ld),
      .valid      (v[i]),
      .rd         (rd_q[i]),
      .data       (data_q[i])
    );
  end

  assign stage_valid = v;
  assign out_valid   = v[DEPTH-1];
  assign out_rd      = rd_q[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];

`ifdef HAZARD_PIPE_FWD_EN
  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    fwd_stage = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (v[j] && (rd_q[j] == q_rs) && (q_rs != REG_AW'(REG_X0))) begin
        fwd_hit   = 1'b1;
        fwd_data  = data_q[j];
        fwd_stage = SW'(j);
      end
    end
  end
`else
  // Pure stall/flush pipeline: no lookup logic.
`endif

endmodule

// File: tb/tb_hazard_pipe.sv
// Directed bench for hazard_pipe (DEPTH=3); forwarding checks are built
// only when HAZARD_PIPE_FWD_EN is defined.
module tb_hazard_pipe;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 3;
  localparam int REG_AW = 5;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic [DEPTH-1:0]  flush;
  logic              in_valid;
  logic [REG_AW-1:0] in_rd;
  logic [WIDTH-1:0]  in_data;
  logic [DEPTH-1:0]  stage_valid;
  logic              out_valid;
  logic [REG_AW-1:0] out_rd;
  logic [WIDTH-1:0]  out_data;
`ifdef HAZARD_PIPE_FWD_EN
  logic [REG_AW-1:0] q_rs;
  logic              fwd_hit;
  logic [WIDTH-1:0]  fwd_data;
  logic [1:0]        fwd_stage;
`endif

  int n_checks;
  int n_fail;

  hazard_pipe #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .stage_valid (stage_valid),
    .out_valid   (out_valid),
    .out_rd      (out_rd),
    .out_data    (out_data)
`ifdef HAZARD_PIPE_FWD_EN
    ,
    .q_rs        (q_rs),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .fwd_stage   (fwd_stage)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [REG_AW-1:0] rd, input logic [WIDTH-1:0] data);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = data;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    stall    = 1'b0;
    flush    = '0;
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
`ifdef HAZARD_PIPE_FWD_EN
    q_rs     = 5'd5;
`endif

    // reset state
    #2;
    check("rst_stage_valid", 32'(stage_valid), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_rd", 32'(out_rd), 32'h0);
    check("rst_out_data", out_data, 32'h0);
`ifdef HAZARD_PIPE_FWD_EN
    check("rst_fwd_hit", 32'(fwd_hit), 32'h0);
`endif
    #10 rst_n = 1'b1;
    tick();

    // shift latency: out after 3rd edge, gone after 4th
    push(5'd5, 32'h1234_5000);
    tick();
    in_valid = 1'b0;
    check("lat_e1_valid", 32'(stage_valid), 32'h1);
    tick();
    check("lat_e2_valid", 32'(stage_valid), 32'h2);
    tick();
    check("lat_e3_out_valid", 32'(out_valid), 32'h1);
    check("lat_e3_out_rd", 32'(out_rd), 32'h5);
    check("lat_e3_out_data", out_data, 32'h1234_5000);
    tick();
    check("lat_e4_out_valid", 32'(out_valid), 32'h0);

    // stall two cycles with entry in stage 1; in_* ignored while stalled
    push(5'd9, 32'h0000_00a9);
    tick();
    in_valid = 1'b0;
    tick();
    check("stall_pre", 32'(stage_valid), 32'h2);
    stall = 1'b1;
    push(5'd3, 32'h0000_0033);
    tick();
    check("stall_c1", 32'(stage_valid), 32'h2);
    tick();
    check("stall_c2", 32'(stage_valid), 32'h2);
    stall    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("stall_out_valid", 32'(stage_valid), 32'h4);
    check("stall_out_rd", 32'(out_rd), 32'h9);
    check("stall_out_data", out_data, 32'h0000_00a9);
    tick();
    check("stall_drain", 32'(stage_valid), 32'h0);

    // flush[1] without stall: bubble moves to stage 2 with old rd/data
    push(5'd4, 32'h0000_0044);
    tick();
    in_valid = 1'b0;
    tick();
    flush = 3'b010;
    tick();
    flush = '0;
    check("flush_ns_valid", 32'(stage_valid), 32'h0);
    check("flush_ns_out_rd", 32'(out_rd), 32'h4);
    check("flush_ns_out_data", out_data, 32'h0000_0044);

    // flush[1] with stall: invalidated in place, rd/data held
    push(5'd6, 32'h0000_0066);
    tick();
    in_valid = 1'b0;
    tick();
    stall = 1'b1;
    flush = 3'b010;
    tick();
    check("flush_st_valid", 32'(stage_valid), 32'h0);
    stall = 1'b0;
    flush = '0;
    tick();
    check("flush_st_bubble_valid", 32'(out_valid), 32'h0);
    check("flush_st_bubble_rd", 32'(out_rd), 32'h6);

    // flush[0] without stall stops the entry entering stage 1 as valid
    push(5'd8, 32'h0000_0088);
    tick();
    in_valid = 1'b0;
    flush = 3'b001;
    tick();
    flush = '0;
    check("flush0_valid", 32'(stage_valid), 32'h0);

    // flush[2] while stalled drops the entry at the output
    push(5'd10, 32'h0000_00aa);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("flush2_pre", 32'(out_valid), 32'h1);
    stall = 1'b1;
    flush = 3'b100;
    tick();
    stall = 1'b0;
    flush = '0;
    check("flush2_st_valid", 32'(stage_valid), 32'h0);

    // fill three entries: stage2 rd7/B, stage1 rd2, stage0 rd7/A
    push(5'd7, 32'hbbbb_0000);
    tick();
    push(5'd2, 32'h0000_0022);
    tick();
    push(5'd7, 32'haaaa_0000);
    tick();
    in_valid = 1'b0;
    stall    = 1'b1;
    check("fill_valid", 32'(stage_valid), 32'h7);
    check("fill_out_data", out_data, 32'hbbbb_0000);
`ifdef HAZARD_PIPE_FWD_EN
    q_rs = 5'd7;
    #1;
    check("fwd7_hit", 32'(fwd_hit), 32'h1);
    check("fwd7_stage", 32'(fwd_stage), 32'h0);
    check("fwd7_data", fwd_data, 32'haaaa_0000);
    q_rs = 5'd2;
    #1;
    check("fwd2_stage", 32'(fwd_stage), 32'h1);
    check("fwd2_data", fwd_data, 32'h0000_0022);
    q_rs = 5'd9;
    #1;
    check("fwd9_hit", 32'(fwd_hit), 32'h0);
    check("fwd9_data", fwd_data, 32'h0);
    check("fwd9_stage", 32'(fwd_stage), 32'h0);
    // same-cycle flush does not alter the lookup
    q_rs  = 5'd7;
    flush = 3'b001;
    #1;
    check("fwd_flush_stage", 32'(fwd_stage), 32'h0);
    check("fwd_flush_data", fwd_data, 32'haaaa_0000);
    flush = '0;
`endif

    // asynchronous reset mid-stream
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(stage_valid), 32'h0);
    check("mid_rst_out_data", out_data, 32'h0);
    check("mid_rst_out_rd", 32'(out_rd), 32'h0);
`ifdef HAZARD_PIPE_FWD_EN
    check("mid_rst_fwd_hit", 32'(fwd_hit), 32'h0);
`endif
    #1 rst_n = 1'b1;
    stall = 1'b0;
    tick();
    check("post_rst_valid", 32'(stage_valid), 32'h0);

    // x0 entry is captured invalid
    push(5'd0, 32'h0000_0055);
    tick();
    in_valid = 1'b0;
    check("x0_valid", 32'(stage_valid), 32'h0);
`ifdef HAZARD_PIPE_FWD_EN
    q_rs = 5'd0;
    #1;
    check("x0_fwd_hit", 32'(fwd_hit), 32'h0);
`endif
    tick();
    tick();
    check("x0_out_valid", 32'(out_valid), 32'h0);
    check("x0_out_data", out_data, 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_pipe.md
# hazard_pipe

Parametrised hazard-tracking pipeline register. Carries a destination-register tag plus a WIDTH-bit result (e.g. an LUI immediate) through DEPTH clocked stages. Each stage has its own valid bit, and the pipe supports stall and per-stage flush. A combinational forwarding lookup over all in-flight entries serves the decode-stage hazard logic. It replaces the fixed single-stage 32-bit hazard register between decode and writeback.

## Interface
- WIDTH, 32, payload width in bits
- DEPTH, 3, number of stages (legal: 1..8)
- REG_AW, 5, register-address width
- clk  in  1  processor clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all stages
- flush  in  DEPTH  flush[i] invalidates the entry in stage i
- in_valid  in  1  entry presented at stage 0 input
- in_rd  in  REG_AW  destination register of the entry
- in_data  in  WIDTH  payload
- stage_valid  out  DEPTH  registered valid bits; bit 0 is the youngest stage
- out_valid  out  1  equals stage_valid[DEPTH-1]
- out_rd  out  REG_AW  rd of the last stage
- out_data  out  WIDTH  payload of the last stage
- q_rs  in  REG_AW  forwarding query address (FWD only)
- fwd_hit  out  1  query matched a valid entry (FWD only)
- fwd_data  out  WIDTH  payload of the matching entry (FWD only)
- fwd_stage  out  max(1,clog2(DEPTH))  index of the matching stage (FWD only)

## Operation
- Reset (rst_n=0, asynchronous): all valid bits, rd and data registers go to 0. As a result, every output reads 0, including fwd_hit.
- Not stalled: stage 0 loads in_valid, in_rd and in_data. Stage i loads from stage i-1.
- Stalled: every stage holds rd and data. in_* are ignored; upstream must keep the entry presented.
- Valid update, applied per stage:
  - stage 0, not stalled: in_valid & (in_rd != 0)
  - stage 0, stalled: v[0] & ~flush[0]
  - stage i, not stalled: v[i-1] & ~flush[i-1]
  - stage i, stalled: v[i] & ~flush[i]
- Flush rules:
  - A flushed entry keeps moving as a bubble: its rd and data still shift, but its valid bit is 0.
  - flush[DEPTH-1] while not stalled has no effect, because that entry leaves the pipe on the same edge.
  - Flush has priority over stall.
- x0 rule: an entry with in_rd == 0 is captured with valid=0. x0 is never a hazard.
- Forwarding lookup (combinational from registered state only):
  - hit_j = v[j] & (rd[j] == q_rs) & (q_rs != 0)
  - fwd_hit = OR of all hit_j
  - fwd_stage is the lowest j with hit_j set, so the youngest entry wins.
  - fwd_data is data of that stage when fwd_hit=1; otherwise fwd_data and fwd_stage are 0.
- Same-cycle flush or stall does not alter the lookup result for that cycle.

## Timing
- Latency: an entry accepted at edge n appears at out_* after edge n+DEPTH-1, provided there are no stalls. For DEPTH=1 it appears after the accepting edge.
- Each stall cycle adds exactly one cycle of latency to every in-flight entry.
- fwd_* settles in the same cycle as a q_rs change; the only register is the pipe state.
- Reset deassertion is synchronised externally. The first capture happens on the first rising edge with rst_n=1.
- Asserting reset mid-stream drops all in-flight entries immediately. No partial state survives.

## Configuration
- HAZARD_PIPE_FWD_EN defined: q_rs and the fwd_* ports exist, and the lookup logic is built.
- Undefined: those ports are absent and the module is a pure stall/flush pipeline. Pipe behaviour is identical in both builds.

## Structure
- Shared package hazard_pkg holds:
  - REG_AW default
  - REG_X0 = 0 constant
  - clog2 function used for fwd_stage width
- One sub-module, hazard_pipe_stage: a single stage holding {valid, rd, data} with stall, flush and asynchronous reset. It is instantiated DEPTH times in a generate loop.
- The lookup is a priority loop in the top level.

## Test plan
- Reset mid-stream: with 3 valid entries in the pipe, pulse rst_n low for half a cycle → stage_valid=000, out_data=0 and fwd_hit=0 immediately, before the next edge.
- Shift latency (DEPTH=3): push rd=5/data=0x12345000, then idle → out_valid=1, out_rd=5, out_data=0x12345000 after the 3rd edge, and out_valid=0 after the 4th edge.
- Stall: with an entry in stage 1, hold stall=1 for 2 cycles → stage_valid=010 is held for both cycles, and the entry reaches out_* 2 cycles late.
- Flush with and without stall:
  - flush[1]=1, stall=0 → stage 2 holds the old stage-1 rd/data with valid=0.
  - flush[1]=1, stall=1 → stage 1 is invalidated in place.
- Forwarding priority: stage 0 holds rd=7/data=A and stage 2 holds rd=7/data=B; query q_rs=7 → fwd_hit=1, fwd_stage=0, fwd_data=A.
- x0 query: push in_rd=0 → stage_valid bit 0 stays 0; q_rs=0 → fwd_hit=0.
